my_instr_fetch: RTL and testbench

//  Instruction fetch + decode-field register for the MiniMIPS datapath. Holds the PC, requests
//  16-bit instruction words from instruction memory via req/ack, and latches each word into an

---
 rtl/my_instr_fetch_pkg.sv | 37 +++
 rtl/my_pc_reg.sv | 41 ++++
 rtl/my_instr_fetch.sv | 127 ++++++++++++
 tb/tb_my_instr_fetch.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/my_instr_fetch_pkg.sv
// Shared definitions for the MiniMIPS instruction fetch stage: opcode
// encodings, instruction field positions and the fetch FSM state encoding.
package my_instr_fetch_pkg;

    // 4-bit MiniMIPS opcodes (instr[15:12]).
    typedef enum logic [3:0] {
        OP_RTYPE = 4'h0,
        OP_ADDI  = 4'h1,
        OP_LW    = 4'h2,
        OP_SW    = 4'h3,
        OP_BEQ   = 4'h4,
        OP_BNE   = 4'h5,
        OP_J     = 4'h6
    } opcode_e;

    // Field bit positions inside a 16-bit instruction word.
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RS_MSB  = 11;
    localparam int RS_LSB  = 9;
    localparam int RT_MSB  = 8;
    localparam int RT_LSB  = 6;
    localparam int RD_MSB  = 5;
    localparam int RD_LSB  = 3;
    localparam int FN_MSB  = 2;
    localparam int FN_LSB  = 0;
    localparam int IMM_MSB = 5;
    localparam int IMM_LSB = 0;

    // Fetch FSM states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/my_pc_reg.sv
// Program counter register: asynchronous reset to RESET_PC, then each cycle
// either loads a new value, increments (modulo 2^PC_W) or holds.
module my_pc_reg #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic [PC_W-1:0] load_val_i,
    input  logic            inc_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // Next PC: a load wins over an increment; the add wraps silently.
    always_comb begin
        // NOTE: default assignment first so every path drives pc_d and no latch is inferred.
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    // PC state register with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so all registers update together at the edge.
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/my_instr_fetch.sv
// Instruction fetch and decode-field register: requests words from
// instruction memory at PC via req/ack, captures them into an instruction
// register, and exposes the op/rs/rt/rd/funct/immediate fields.
module my_instr_fetch
    import my_instr_fetch_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               id_ready,
    output logic               id_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc_out,
    output logic [3:0]         opcode,
    output logic [2:0]         rs,
    output logic [2:0]         rt,
    output logic [2:0]         rd,
    output logic [2:0]         funct,
    output logic [5:0]         immediatefield
);

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc_out_q, pc_out_d;
    logic               valid_q, valid_d;
    logic               pc_load, pc_inc;
    logic [PC_W-1:0]    pc;

    my_pc_reg #(
        .PC_W    (PC_W),
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .reset     (reset),
        .load_i    (pc_load),
        .load_val_i(branch_target),
        .inc_i     (pc_inc),
        .pc_o      (pc)
    );

    // Fetch FSM next state, capture control and request output.
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        pc_load  = 1'b0;
        pc_inc   = 1'b0;
        imem_req = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d  = imem_rdata;
                    pc_out_d = pc;
                    pc_inc   = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (id_ready) begin
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A redirect overrides everything: any same-cycle ack is dropped, the
        // held instruction is flushed, and the request is withdrawn this cycle
        // so memory sees a fresh request at the target on the next cycle.
        if (branch_taken) begin
            instr_d  = instr_q;
            pc_out_d = pc_out_q;
            valid_d  = 1'b0;
            pc_inc   = 1'b0;
            pc_load  = 1'b1;
            imem_req = 1'b0;
            state_d  = S_REQ;
        end
    end

    // FSM state, instruction register and its PC, with async reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            instr_q  <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
        end
    end

    assign imem_addr = pc;
    assign id_valid  = valid_q;
    assign instr     = instr_q;
    assign pc_out    = pc_out_q;

    // Decode fields are plain slices, so they only move when instr moves.
    assign opcode         = instr_q[OP_MSB:OP_LSB];
    assign rs             = instr_q[RS_MSB:RS_LSB];
    assign rt             = instr_q[RT_MSB:RT_LSB];
    assign rd             = instr_q[RD_MSB:RD_LSB];
    assign funct          = instr_q[FN_MSB:FN_LSB];
    assign immediatefield = instr_q[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_my_instr_fetch.sv
// Self-checking bench for my_instr_fetch: directed scenarios followed by
// randomized fetch/stall/branch traffic against a reference model and a
// scoreboard of expected (pc, instruction) captures.
module tb_my_instr_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        id_ready;
    logic        id_valid;
    logic [15:0] instr;
    logic [31:0] pc_out;
    logic [3:0]  opcode;
    logic [2:0]  rs, rt, rd, funct;
    logic [5:0]  immediatefield;

    always #5 clk = ~clk;

    my_instr_fetch #(
        .PC_W    (32),
        .INSTR_W (16),
        .RESET_PC(32'h0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .id_ready      (id_ready),
        .id_valid      (id_valid),
        .instr         (instr),
        .pc_out        (pc_out),
        .opcode        (opcode),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .funct         (funct),
        .immediatefield(immediatefield)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] ins;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [31:0] model_pc;
    bit          model_valid;
    bit          model_idle;
    int          wait_cnt;
    int          max_wait;
    bit          ovr_en;
    logic [15:0] ovr_data;
    bit          req_seen;
    logic [31:0] addr_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        h = (a * 32'h9E37_79B1) ^ 32'h5A3C_C3A5;
        return h[23:8];
    endfunction

    function automatic logic [31:0] sext6(input logic [5:0] v);
        return {{26{v[5]}}, v};
    endfunction

    // One clock cycle: apply inputs, model the memory, then update the model.
    task automatic step(input logic br, input logic [31:0] tgt, input logic rdy, input logic allow_ack);
        bit accepted;
        @(negedge clk);
        branch_taken = 1'b0;
        id_ready     = rdy;
        #1;
        req_seen  = imem_req;
        addr_seen = imem_addr;
        check("req", {31'b0, imem_req}, {31'b0, !model_idle && !model_valid});
        check("id_valid", {31'b0, id_valid}, {31'b0, model_valid});
        if (req_seen) check("imem_addr", imem_addr, model_pc);
        if (req_seen && allow_ack && wait_cnt == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = ovr_en ? ovr_data : mem_word(imem_addr);
            wait_cnt   = $urandom_range(max_wait);
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 16'($urandom);
            if (req_seen && wait_cnt > 0) wait_cnt--;
        end
        branch_taken  = br;
        branch_target = tgt;
        @(posedge clk);
        accepted = req_seen && imem_ack && !br;
        if (br) begin
            model_pc    = tgt;
            model_valid = 1'b0;
        end else if (accepted) begin
            exp_q.push_back('{pc: model_pc, ins: imem_rdata});
            model_pc    = model_pc + 32'd1;
            model_valid = 1'b1;
        end else if (model_valid && rdy) begin
            model_valid = 1'b0;
        end
        model_idle = 1'b0;
    endtask

    // Asynchronous reset, optionally with a stray ack arriving during and just after it.
    task automatic do_reset(input bit late_ack);
        reset        = 1'b1;
        branch_taken = 1'b0;
        #1;
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_valid", {31'b0, id_valid}, 32'd0);
        check("rst_instr", {16'b0, instr}, 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        check("rst_fields", {12'b0, opcode, rs, rt, rd, funct, immediatefield}, 32'd0);
        imem_ack   = late_ack;
        imem_rdata = 16'hBEEF;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        model_pc    = 32'h0;
        model_valid = 1'b0;
        model_idle  = 1'b1;
        wait_cnt    = 0;
        #1;
        check("idle_req", {31'b0, imem_req}, 32'd0);
        @(posedge clk);
        #1;
        check("late_ack_instr", {16'b0, instr}, 32'd0);
        check("late_ack_valid", {31'b0, id_valid}, 32'd0);
        model_idle = 1'b0;
    endtask

    // Monitor: each new presentation of id_valid is matched against the scoreboard.
    exp_t mon_e;
    bit   prev_v = 1'b0;
    logic [15:0] held;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (id_valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: actual instr=%h pc=%h required no output", instr, pc_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_instr", {16'b0, instr}, {16'b0, mon_e.ins});
                    check("sb_pc_out", pc_out, mon_e.pc);
                    check("sb_opcode", {28'b0, opcode}, {28'b0, mon_e.ins[15:12]});
                    check("sb_rs_rt", {26'b0, rs, rt}, {26'b0, mon_e.ins[11:6]});
                    check("sb_rd_funct", {26'b0, rd, funct}, {26'b0, mon_e.ins[5:0]});
                    check("sb_imm", {26'b0, immediatefield}, {26'b0, mon_e.ins[5:0]});
                end
            end else if (id_valid && prev_v) begin
                check("stall_stable", {16'b0, instr}, {16'b0, held});
            end
            prev_v = id_valid;
            held   = instr;
        end
    end

    initial begin
        logic [31:0] tgt;
        imem_ack      = 1'b0;
        imem_rdata    = 16'h0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        id_ready      = 1'b0;
        max_wait      = 0;
        ovr_en        = 1'b0;
        ovr_data      = 16'h0;
        model_pc      = 32'h0;
        model_valid   = 1'b0;
        model_idle    = 1'b1;
        wait_cnt      = 0;
        #1;
        do_reset(1'b0);

        // Zero-wait memory, always ready: one fetch every two cycles.
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            check("t1_req_pattern", {31'b0, req_seen}, {31'b0, (k % 2) == 0});
            if ((k % 2) == 0) check("t1_addr", addr_seen, 32'(k / 2));
        end

        // Field split on known words.
        do_reset(1'b0);
        ovr_en   = 1'b1;
        ovr_data = 16'hA7C5;
        step(1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        check("t2_opcode", {28'b0, opcode}, 32'hA);
        check("t2_rs", {29'b0, rs}, 32'd3);
        check("t2_rt", {29'b0, rt}, 32'd7);
        check("t2_rd", {29'b0, rd}, 32'd0);
        check("t2_funct", {29'b0, funct}, 32'd5);
        check("t2_imm", {26'b0, immediatefield}, 32'h05);
        check("t2_sext_pos", sext6(immediatefield), 32'h0000_0005);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        ovr_data = 16'h003F;
        step(1'b0, 32'h0, 1'b0, 1'b1);
        ovr_en = 1'b0;
        #1;
        check("t2_imm_neg", {26'b0, immediatefield}, 32'h3F);
        check("t2_sext_neg", sext6(immediatefield), 32'hFFFF_FFFF);

        // Five-cycle stall in HOLD, then resume.
        repeat (5) step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check("t3_resume_req", {31'b0, req_seen}, 32'd1);

        // Branch coinciding with an ack, then a branch that flushes HOLD.
        step(1'b1, 32'h40, 1'b0, 1'b1);
        #1;
        check("t4_instr_kept", {16'b0, instr}, 32'h003F);
        check("t4_valid_low", {31'b0, id_valid}, 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check("t4_addr_40", addr_seen, 32'h40);
        step(1'b1, 32'h80, 1'b1, 1'b1);
        #1;
        check("t4_flush", {31'b0, id_valid}, 32'd0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check("t4_addr_80", addr_seen, 32'h80);

        // PC wrap from all-ones.
        step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check("t5_addr_max", addr_seen, 32'hFFFF_FFFF);
        #1;
        check("t5_pc_out_max", pc_out, 32'hFFFF_FFFF);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("t5_wrap_addr", addr_seen, 32'h0);

        // Reset in the middle of an outstanding request, with a late ack.
        step(1'b0, 32'h0, 1'b1, 1'b0);
        #2;
        check("t6_req_pending", {31'b0, imem_req}, 32'd1);
        do_reset(1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check("t6_restart_addr", addr_seen, 32'h0);

        // Randomized traffic: variable memory latency, stalls and redirects.
        max_wait = 3;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(11) == 0) begin
                tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFFE + 32'($urandom_range(1))) : $urandom;
                step(1'b1, tgt, 1'($urandom_range(1)), 1'b1);
            end else begin
                step(1'b0, 32'h0, 1'($urandom_range(9) < 7), 1'b1);
            end
        end

        // Drain: nothing new is acked, so every capture has been presented.
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
